// File: rtl/vic20_xfer_pkg.sv
// vic20_xfer_pkg: shared state type, BASIC pointer addresses and size helper for the PRG transfer path.
package vic20_xfer_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, READY, SERVE} xfer_state_t;

    localparam logic [15:0] ADDR_TXTTAB = 16'h002B;
    localparam logic [15:0] ADDR_VARTAB = 16'h002D;
    localparam logic [15:0] RAM_TOP     = 16'hA000;
    localparam int          PRG_HDR_LEN = 2;

    // File length: header plus RAM[start .. end-1], header only when the program is empty.
    function automatic logic [16:0] prg_size(input logic [15:0] s, input logic [15:0] e);
        return (e > s) ? 17'(PRG_HDR_LEN) + ({1'b0, e} - {1'b0, s}) : 17'(PRG_HDR_LEN);
    endfunction

endpackage

// File: rtl/vic20_mem_rd_seq.sv
// vic20_mem_rd_seq: one-cycle RAM read strobe plus a MEM_LAT-deep valid pipe that flags
// the cycle in which mem_data holds the requested byte.
module vic20_mem_rd_seq #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        req,
    input  logic [15:0] addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        done
);

    logic [MEM_LAT-1:0] vld;

    assign done = vld[MEM_LAT-1];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            vld      <= '0;
        end else begin
            mem_rd <= req;
            if (req)
                mem_addr <= addr;
            vld <= MEM_LAT'({vld, mem_rd});
        end
    end

endmodule

// File: rtl/vic20_prg_saver.sv
// vic20_prg_saver: reads TXTTAB/VARTAB from VIC-20 RAM and serves the BASIC program as a .PRG upload.
// Define VIC20_SAVE_CLAMP_EN to clamp the end pointer to RAM_TOP, matching the loader's limit.
module vic20_prg_saver
    import vic20_xfer_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_ready,
    output logic [16:0] o_size,
    output logic        o_empty,
    output logic        o_clamped,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        o_din_valid
);

    xfer_state_t state;
    logic [1:0]  idx, nidx;
    logic [15:0] start_ptr, end_raw, end_new, req_addr;
    logic [7:0]  end_lo;
    logic        done, req, fetch_go, fetch_next, accept, in_range, serve_go, clamp;

    assign o_busy     = (state == FETCH) || (state == SERVE);
    assign fetch_go   = i_start && ((state == IDLE) || (state == READY));
    assign fetch_next = (state == FETCH) && done && (idx != 2'd3);
    assign accept     = (state == READY) && ioctl_rd && ioctl_upload && !i_start;
    assign in_range   = (ioctl_addr >= 25'd2) && (ioctl_addr < {8'd0, o_size});
    assign serve_go   = accept && in_range;
    assign req        = fetch_go || fetch_next || serve_go;
    assign nidx       = fetch_go ? 2'd0 : idx + 2'd1;
    // Pointer bytes live at $2B..$2E; nidx[1] selects the VARTAB pair.
    assign req_addr   = serve_go ? start_ptr + ioctl_addr[15:0] - 16'd2
                                 : (nidx[1] ? ADDR_VARTAB : ADDR_TXTTAB) + {15'd0, nidx[0]};
    assign end_raw    = {mem_data, end_lo};

`ifdef VIC20_SAVE_CLAMP_EN
    assign clamp   = end_raw > RAM_TOP;
    assign end_new = clamp ? RAM_TOP : end_raw;
`else
    assign clamp   = 1'b0;
    assign end_new = end_raw;
`endif

    vic20_mem_rd_seq #(.MEM_LAT(MEM_LAT)) u_seq (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .req      (req),
        .addr     (req_addr),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .done     (done)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            start_ptr   <= '0;
            end_lo      <= '0;
            o_ready     <= 1'b0;
            o_size      <= '0;
            o_empty     <= 1'b0;
            o_clamped   <= 1'b0;
            ioctl_din   <= '0;
            o_din_valid <= 1'b0;
        end else begin
            o_din_valid <= 1'b0;
            case (state)
                IDLE, READY: begin
                    if (fetch_go) begin
                        state   <= FETCH;
                        idx     <= 2'd0;
                        o_ready <= 1'b0;
                    end else if (serve_go) begin
                        state <= SERVE;
                    end else if (accept) begin
                        ioctl_din   <= (ioctl_addr == 25'd0) ? start_ptr[7:0] :
                                       (ioctl_addr == 25'd1) ? start_ptr[15:8] : 8'h00;
                        o_din_valid <= 1'b1;
                    end
                end
                FETCH: begin
                    if (done) begin
                        idx <= idx + 2'd1;
                        case (idx)
                            2'd0: start_ptr[7:0]  <= mem_data;
                            2'd1: start_ptr[15:8] <= mem_data;
                            2'd2: end_lo          <= mem_data;
                            default: begin
                                state     <= READY;
                                o_ready   <= 1'b1;
                                o_size    <= prg_size(start_ptr, end_new);
                                o_empty   <= !(end_new > start_ptr);
                                o_clamped <= clamp;
                            end
                        endcase
                    end
                end
                default: begin
                    if (done) begin
                        ioctl_din   <= mem_data;
                        o_din_valid <= 1'b1;
                        state       <= READY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vic20_prg_saver.sv
// tb_vic20_prg_saver: drives MEM_LAT=1 and MEM_LAT=3 savers in lockstep against a RAM model
// and a pointer/file-offset reference model.
module tb_vic20_prg_saver;

    logic        clk_sys = 1'b0;
    logic        reset, i_start, ioctl_upload, ioctl_rd;
    logic [24:0] ioctl_addr;
    logic        busy [2], rdy [2], emp [2], clmp [2], mrd [2], dv [2];
    logic [16:0] size [2];
    logic [15:0] maddr [2];
    logic [7:0]  mdata [2], din [2];

    logic [7:0]        ram [65536];
    logic [3:0]        vp [2];
    logic [3:0][15:0]  ap [2];
    logic [7:0]        junk [2];
    logic              rdy_d [2];
    logic [23:0]       cyc = '0;
    logic [39:0]       mrq0[$], mrq1[$], rsp0[$], rsp1[$], rdq0[$], rdq1[$];

    int passed = 0, total = 0, failed = 0;
    int ms, me, msize;
    bit mclamp;

    always #5 clk_sys = ~clk_sys;

    function automatic int lat(input int g);
        return g == 0 ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        vic20_prg_saver #(.MEM_LAT(g == 0 ? 1 : 3)) dut (
            .clk_sys      (clk_sys),
            .reset        (reset),
            .i_start      (i_start),
            .o_busy       (busy[g]),
            .o_ready      (rdy[g]),
            .o_size       (size[g]),
            .o_empty      (emp[g]),
            .o_clamped    (clmp[g]),
            .mem_addr     (maddr[g]),
            .mem_rd       (mrd[g]),
            .mem_data     (mdata[g]),
            .ioctl_upload (ioctl_upload),
            .ioctl_rd     (ioctl_rd),
            .ioctl_addr   (ioctl_addr),
            .ioctl_din    (din[g]),
            .o_din_valid  (dv[g])
        );
    end

    // RAM returns the addressed byte exactly MEM_LAT cycles after mem_rd, noise otherwise.
    always_comb
        for (int g = 0; g < 2; g++)
            mdata[g] = vp[g][lat(g) - 1] ? ram[ap[g][lat(g) - 1]] : junk[g];

    always @(posedge clk_sys) begin
        for (int g = 0; g < 2; g++) begin
            vp[g]    <= {vp[g][2:0], mrd[g]};
            ap[g]    <= {ap[g][2:0], maddr[g]};
            junk[g]  <= 8'($urandom);
            rdy_d[g] <= rdy[g];
        end
        if (mrd[0]) mrq0.push_back({cyc, maddr[0]});
        if (mrd[1]) mrq1.push_back({cyc, maddr[1]});
        if (dv[0]) rsp0.push_back({cyc, 8'h00, din[0]});
        if (dv[1]) rsp1.push_back({cyc, 8'h00, din[1]});
        if (rdy[0] && !rdy_d[0]) rdq0.push_back({cyc, 16'h0});
        if (rdy[1] && !rdy_d[1]) rdq1.push_back({cyc, 16'h0});
        cyc <= cyc + 24'd1;
    end

    function automatic int nq(input int g, input int k);
        return k == 0 ? (g != 0 ? mrq1.size() : mrq0.size()) :
               k == 1 ? (g != 0 ? rsp1.size() : rsp0.size()) :
                        (g != 0 ? rdq1.size() : rdq0.size());
    endfunction

    function automatic logic [39:0] qat(input int g, input int k, input int i);
        if (i >= nq(g, k)) return '1;
        return k == 0 ? (g != 0 ? mrq1[i] : mrq0[i]) :
               k == 1 ? (g != 0 ? rsp1[i] : rsp0[i]) :
                        (g != 0 ? rdq1[i] : rdq0[i]);
    endfunction

    function automatic logic [63:0] outs(input int g);
        return 64'({busy[g], rdy[g], size[g], emp[g], clmp[g], mrd[g], maddr[g], din[g], dv[g]});
    endfunction

    task automatic chk(input string tag, input int g, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s [MEM_LAT=%0d]: observed %0h expected %0h", tag, lat(g), obs, exp);
        end
    endtask

    function automatic void model_ptrs();
        ms = {16'd0, ram[16'h2C], ram[16'h2B]};
        me = {16'd0, ram[16'h2E], ram[16'h2D]};
        mclamp = 1'b0;
`ifdef VIC20_SAVE_CLAMP_EN
        if (me > 'hA000) begin
            me = 'hA000;
            mclamp = 1'b1;
        end
`endif
        msize = me > ms ? 2 + me - ms : 2;
    endfunction

    function automatic logic [7:0] model_byte(input int off);
        if (off == 0) return ms[7:0];
        if (off == 1) return ms[15:8];
        return off < msize ? ram[16'(ms + off - 2)] : 8'h00;
    endfunction

    task automatic fetch(input logic [15:0] s, input logic [15:0] e);
        int c, m0 [2], r0 [2];
        ram[16'h2B] = s[7:0];
        ram[16'h2C] = s[15:8];
        ram[16'h2D] = e[7:0];
        ram[16'h2E] = e[15:8];
        model_ptrs();
        for (int g = 0; g < 2; g++) begin
            m0[g] = nq(g, 0);
            r0[g] = nq(g, 2);
        end
        c = int'(cyc);
        i_start = 1'b1;
        @(negedge clk_sys);
        i_start = 1'b0;
        for (int g = 0; g < 2; g++) chk("fetch_busy", g, {busy[g], rdy[g]}, 2'b10);
        repeat (20) @(negedge clk_sys);
        for (int g = 0; g < 2; g++) begin
            chk("ready_cycle", g, qat(g, 2, r0[g]) >> 16, c + 1 + 4 * (lat(g) + 1));
            chk("fetch_rd_cnt", g, nq(g, 0) - m0[g], 4);
            for (int i = 0; i < 4; i++)
                chk("fetch_rd", g, qat(g, 0, m0[g] + i), {24'(c + 1 + i * (lat(g) + 1)), 16'h2B + 16'(i)});
            chk("size", g, size[g], msize);
            chk("flags", g, {rdy[g], busy[g], emp[g], clmp[g]}, {1'b1, 1'b0, msize == 2, mclamp});
        end
    endtask

    task automatic req(input logic [24:0] off, input bit twice, input bit drop_upl);
        int c, n0 [2], m0 [2];
        bit srv;
        srv = off >= 2 && off < msize;
        for (int g = 0; g < 2; g++) begin
            n0[g] = nq(g, 1);
            m0[g] = nq(g, 0);
        end
        c = int'(cyc);
        ioctl_addr = off;
        ioctl_rd = 1'b1;
        @(negedge clk_sys);
        for (int g = 0; g < 2; g++) chk("serve_busy", g, busy[g], srv);
        ioctl_rd = twice;
        ioctl_addr = off + 25'd1;
        if (drop_upl) ioctl_upload = 1'b0;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        repeat (8) @(negedge clk_sys);
        ioctl_upload = 1'b1;
        for (int g = 0; g < 2; g++) begin
            logic [39:0] r, m;
            r = qat(g, 1, n0[g]);
            m = qat(g, 0, m0[g]);
            chk("rsp_cnt", g, nq(g, 1) - n0[g], 1);
            chk("rsp_data", g, r[7:0], model_byte(int'(off)));
            chk("rsp_cycle", g, r[39:16], c + (srv ? lat(g) + 2 : 1));
            chk("mrd_cnt", g, nq(g, 0) - m0[g], srv);
            if (srv) chk("mrd_cyc_addr", g, m, {24'(c + 1), 16'(ms + int'(off) - 2)});
        end
    endtask

    initial begin
        int n0 [2], m0 [2];
        logic [15:0] rs;
        reset = 1'b1;
        i_start = 1'b0;
        ioctl_upload = 1'b1;
        ioctl_rd = 1'b0;
        ioctl_addr = '0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        ram[16'h1001] = 8'h0B;
        repeat (3) @(negedge clk_sys);
        for (int g = 0; g < 2; g++) chk("reset_outs", g, outs(g), 0);
        reset = 1'b0;
        @(negedge clk_sys);

        fetch(16'h1001, 16'h1011);
        for (int g = 0; g < 2; g++) chk("spec_size18", g, size[g], 18);
        req(25'd0, 0, 0);
        req(25'd1, 0, 0);
        req(25'd2, 0, 0);
        req(25'd17, 0, 0);
        req(25'd18, 0, 0);
        req(25'h100_0002, 0, 0);
        repeat (8) req(25'($urandom_range(0, 21)), 0, 0);
        req(25'd5, 1, 0);
        req(25'd7, 0, 1);

        ioctl_upload = 1'b0;
        for (int g = 0; g < 2; g++) begin
            n0[g] = nq(g, 1);
            m0[g] = nq(g, 0);
        end
        ioctl_addr = 25'd3;
        ioctl_rd = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        repeat (8) @(negedge clk_sys);
        for (int g = 0; g < 2; g++) chk("no_upload_drop", g, {8'(nq(g, 1) - n0[g]), 8'(nq(g, 0) - m0[g])}, 0);
        ioctl_upload = 1'b1;

        fetch(16'h1201, 16'h1201);
        req(25'd2, 0, 0);
        req(25'd1, 0, 0);
        fetch(16'h1001, 16'hB000);
        req(25'(msize - 1), 0, 0);
        req(25'(msize), 0, 0);
        req(25'($urandom_range(2, msize - 1)), 0, 0);
        fetch(16'h2000, 16'h1000);
        req(25'd2, 0, 0);
        req(25'd0, 0, 0);
        repeat (3) begin
            rs = 16'($urandom);
            fetch(rs, rs + 16'($urandom_range(0, 400)));
            repeat (4) req(25'($urandom_range(0, msize + 2)), 0, 0);
        end

        i_start = 1'b1;
        @(negedge clk_sys);
        i_start = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        for (int g = 0; g < 2; g++) begin
            chk("reset_mid_fetch", g, outs(g), 0);
            m0[g] = nq(g, 0);
        end
        reset = 1'b0;
        repeat (12) @(negedge clk_sys);
        for (int g = 0; g < 2; g++) chk("reset_quiet", g, {8'(nq(g, 0) - m0[g]), rdy[g], busy[g]}, 0);
        fetch(16'h1001, 16'h1011);
        req(25'd2, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
